// File: rtl/sdram_burst_sched.sv
// rtl/sdram_burst_sched.sv - write/read burst scheduler for an SDRAM ring buffer
//
// Moves fixed-length bursts between a write FIFO, an SDRAM ring region and a
// read FIFO by driving the single sdram_ctrl request port. Data words never
// pass through here; only requests, addresses and FIFO pop/push strobes do.
//
// Ports:
//   clk_100m, rstn          clock and asynchronous active-low reset
//   rd_en                   read bursts allowed
//   wr_fifo_level           words held in the write FIFO
//   rd_fifo_level           words held in the read FIFO
//   wr_fifo_rden            write FIFO pop, copy of wr_ack
//   rd_fifo_wren            read FIFO push, copy of rd_ack
//   wr_req/wr_addr/wr_burst_len/wr_ack   write burst handshake with sdram_ctrl
//   rd_req/rd_addr/rd_burst_len/rd_ack   read burst handshake with sdram_ctrl
//   ring_fill               words written to the ring and not yet read back
//   busy                    a burst (or its DONE cycle) is in progress
//   err                     sticky: ack seen outside its burst or both acks at once
module sdram_burst_sched #(
    parameter int ADDR_W       = 24,
    parameter int LEN_W        = 10,
    parameter int BURST_LEN    = 10,
    parameter int BASE_ADDR    = 0,
    parameter int REGION_WORDS = 1000,
    parameter int FIFO_DEPTH   = 512
) (
    input  logic              clk_100m,
    input  logic              rstn,
    input  logic              rd_en,
    input  logic [LEN_W-1:0]  wr_fifo_level,
    input  logic [LEN_W-1:0]  rd_fifo_level,
    output logic              wr_fifo_rden,
    output logic              rd_fifo_wren,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LEN_W-1:0]  wr_burst_len,
    input  logic              wr_ack,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LEN_W-1:0]  rd_burst_len,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] ring_fill,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BURST_A  = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(BASE_ADDR + REGION_WORDS);
    localparam logic [ADDR_W:0]   REGION_X = (ADDR_W+1)'(REGION_WORDS);
    localparam logic [LEN_W-1:0]  BURST_L  = LEN_W'(BURST_LEN);
    localparam logic [LEN_W-1:0]  BURST_M1 = LEN_W'(BURST_LEN - 1);
    localparam logic [LEN_W:0]    RD_LIM   = (LEN_W+1)'(FIFO_DEPTH - BURST_LEN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               wr_req_q, wr_req_d;
    logic               rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  fill_q, fill_d;
    logic [LEN_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic               last_wr_q, last_wr_d;   // 1: last grant went to WR
    logic               err_q, err_d;
    // Levels and rd_en are sampled once so the grant decision sees stable values.
    logic               rd_en_q;
    logic [LEN_W-1:0]   wr_lvl_q;
    logic [LEN_W-1:0]   rd_lvl_q;

    logic wr_ok, rd_ok;

    function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
        logic [ADDR_W-1:0] n;
        n = p + BURST_A;
        return (n == END_A) ? BASE_A : n;
    endfunction

    // The fill check is done one bit wider so fill+BURST_LEN cannot wrap.
    assign wr_ok = (wr_lvl_q >= BURST_L) &&
                   (({1'b0, fill_q} + {1'b0, BURST_A}) <= REGION_X);
    assign rd_ok = rd_en_q && (fill_q >= BURST_A) &&
                   ({1'b0, rd_lvl_q} <= RD_LIM);

    always_comb begin
        state_d   = state_q;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        fill_d    = fill_q;
        ack_cnt_d = ack_cnt_q;
        last_wr_d = last_wr_q;

        case (state_q)
            IDLE: begin
                ack_cnt_d = '0;
                if (wr_ok && (!rd_ok || !last_wr_q)) begin
                    state_d   = WR_BURST;
                    wr_req_d  = 1'b1;
                    last_wr_d = 1'b1;
                end else if (rd_ok && (!wr_ok || last_wr_q)) begin
                    state_d   = RD_BURST;
                    rd_req_d  = 1'b1;
                    last_wr_d = 1'b0;
                end
            end
            WR_BURST: begin
                if (wr_ack) begin
                    if (ack_cnt_q == BURST_M1) begin
                        wr_req_d  = 1'b0;
                        ack_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        ack_cnt_d = ack_cnt_q + 1'b1;
                    end
                end
            end
            RD_BURST: begin
                if (rd_ack) begin
                    if (ack_cnt_q == BURST_M1) begin
                        rd_req_d  = 1'b0;
                        ack_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        ack_cnt_d = ack_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // last_wr_q still names the burst that just finished.
                if (last_wr_q) begin
                    wr_ptr_d = ptr_next(wr_ptr_q);
                    fill_d   = fill_q + BURST_A;
                end else begin
                    rd_ptr_d = ptr_next(rd_ptr_q);
                    fill_d   = fill_q - BURST_A;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign err_d = err_q |
                   (wr_ack && (state_q != WR_BURST)) |
                   (rd_ack && (state_q != RD_BURST)) |
                   (wr_ack && rd_ack);

    always_ff @(posedge clk_100m or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            wr_ptr_q  <= BASE_A;
            rd_ptr_q  <= BASE_A;
            fill_q    <= '0;
            ack_cnt_q <= '0;
            last_wr_q <= 1'b0;
            err_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_lvl_q  <= '0;
            rd_lvl_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            ack_cnt_q <= ack_cnt_d;
            last_wr_q <= last_wr_d;
            err_q     <= err_d;
            rd_en_q   <= rd_en;
            wr_lvl_q  <= wr_fifo_level;
            rd_lvl_q  <= rd_fifo_level;
        end
    end

    assign wr_fifo_rden = wr_ack;
    assign rd_fifo_wren = rd_ack;
    assign wr_req       = wr_req_q;
    assign rd_req       = rd_req_q;
    assign wr_addr      = wr_ptr_q;
    assign rd_addr      = rd_ptr_q;
    assign wr_burst_len = BURST_L;
    assign rd_burst_len = BURST_L;
    assign ring_fill    = fill_q;
    assign busy         = (state_q != IDLE);
    assign err          = err_q;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// tb/tb_sdram_burst_sched.sv - directed table-driven bench for sdram_burst_sched
module tb_sdram_burst_sched;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 10;
    localparam int BL     = 10;
    localparam int REGION = 30;
    localparam int DEPTH  = 512;

    logic              clk_100m = 1'b0;
    logic              rstn     = 1'b0;
    logic              rd_en    = 1'b0;
    logic [LEN_W-1:0]  wr_fifo_level = '0;
    logic [LEN_W-1:0]  rd_fifo_level = '0;
    logic              wr_fifo_rden, rd_fifo_wren;
    logic              wr_req, rd_req;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [LEN_W-1:0]  wr_burst_len, rd_burst_len;
    logic              wr_ack = 1'b0;
    logic              rd_ack = 1'b0;
    logic [ADDR_W-1:0] ring_fill;
    logic              busy, err;

    sdram_burst_sched #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_LEN(BL),
        .BASE_ADDR(0), .REGION_WORDS(REGION), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_100m(clk_100m), .rstn(rstn), .rd_en(rd_en),
        .wr_fifo_level(wr_fifo_level), .rd_fifo_level(rd_fifo_level),
        .wr_fifo_rden(wr_fifo_rden), .rd_fifo_wren(rd_fifo_wren),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_burst_len(wr_burst_len), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_burst_len(rd_burst_len), .rd_ack(rd_ack),
        .ring_fill(ring_fill), .busy(busy), .err(err)
    );

    always #5 clk_100m = ~clk_100m;

    // grant: 0 = none expected, 1 = write burst, 2 = read burst
    typedef struct {
        bit re;
        int wl;
        int rl;
        int grant;
        int addr;
        int nxt;
        int fill;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit re, int wl, int rl, int g, int a, int n, int f);
        vec_t v;
        v.re = re; v.wl = wl; v.rl = rl; v.grant = g; v.addr = a; v.nxt = n; v.fill = f;
        return v;
    endfunction

    task automatic set_in(input bit re, input int wl, input int rl);
        rd_en         = re;
        wr_fifo_level = LEN_W'(wl);
        rd_fifo_level = LEN_W'(rl);
    endtask

    task automatic do_reset();
        @(negedge clk_100m);
        rstn = 1'b0;
        set_in(0, 0, 0);
        wr_ack = 1'b0;
        rd_ack = 1'b0;
        repeat (2) @(negedge clk_100m);
        rstn = 1'b1;
    endtask

    // Applies one vector: either checks that nothing is granted, or waits for the
    // expected grant, acks the full burst with gaps and checks the aftermath.
    task automatic apply_vec(input vec_t v, input string tag);
        int  t;
        bit  is_wr;
        int  pulses;
        logic req_now;
        set_in(v.re, v.wl, v.rl);
        if (v.grant == 0) begin
            bit seen;
            seen = 0;
            repeat (30) begin
                @(negedge clk_100m);
                if (wr_req || rd_req) seen = 1;
            end
            chk({tag, ".no_grant"}, seen, 0);
            chk({tag, ".fill"}, ring_fill, v.fill);
            set_in(0, 0, 0);
            return;
        end
        is_wr = (v.grant == 1);
        t = 0;
        while (!wr_req && !rd_req && t < 30) begin
            @(negedge clk_100m);
            t++;
        end
        chk({tag, ".grant_seen"}, wr_req | rd_req, 1);
        if (!(wr_req | rd_req)) begin
            set_in(0, 0, 0);
            return;
        end
        chk({tag, ".grant_wr"}, wr_req, is_wr);
        chk({tag, ".grant_rd"}, rd_req, !is_wr);
        chk({tag, ".addr"}, is_wr ? wr_addr : rd_addr, v.addr);
        chk({tag, ".blen"}, is_wr ? wr_burst_len : rd_burst_len, BL);
        pulses = 0;
        for (int k = 0; k < BL; k++) begin
            if (k == 3 || k == 7) begin
                @(negedge clk_100m);
                req_now = is_wr ? wr_req : rd_req;
                chk({tag, ".req_gap"}, req_now, 1);
            end
            if (is_wr) wr_ack = 1'b1; else rd_ack = 1'b1;
            #1;
            if (is_wr ? wr_fifo_rden : rd_fifo_wren) pulses++;
            if (is_wr ? rd_fifo_wren : wr_fifo_rden) pulses += 100;
            @(negedge clk_100m);
            wr_ack = 1'b0;
            rd_ack = 1'b0;
            if (k < BL - 1) begin
                req_now = is_wr ? wr_req : rd_req;
                if (req_now !== 1'b1) chk({tag, ".req_hold"}, req_now, 1);
            end
        end
        set_in(0, 0, 0);
        chk({tag, ".strobes"}, pulses, BL);
        chk({tag, ".req_drop"}, wr_req | rd_req, 0);
        chk({tag, ".addr_stable"}, is_wr ? wr_addr : rd_addr, v.addr);
        chk({tag, ".busy_done"}, busy, 1);
        @(negedge clk_100m);
        chk({tag, ".busy_idle"}, busy, 0);
        chk({tag, ".fill"}, ring_fill, v.fill);
        chk({tag, ".ptr_next"}, is_wr ? wr_addr : rd_addr, v.nxt);
    endtask

    vec_t t3[4];
    vec_t tbl[17];

    initial begin
        // Ring wrap / full with writes only.
        t3[0] = mk(0, 10, 0, 1,  0, 10, 10);
        t3[1] = mk(0, 10, 0, 1, 10, 20, 20);
        t3[2] = mk(0, 10, 0, 1, 20,  0, 30);
        t3[3] = mk(0, 10, 0, 0,  0,  0, 30);

        // Mixed sequence: single write, read gating, round-robin, wrap, refill.
        tbl[0]  = mk(0,  0,   0, 0,  0,  0,  0);
        tbl[1]  = mk(1,  5,   0, 0,  0,  0,  0);
        tbl[2]  = mk(0, 10,   0, 1,  0, 10, 10);
        tbl[3]  = mk(1,  0, 503, 0,  0,  0, 10);
        tbl[4]  = mk(1,  0, 502, 2,  0, 10,  0);
        tbl[5]  = mk(1, 20,   0, 1, 10, 20, 10);
        tbl[6]  = mk(1, 20,   0, 2, 10, 20,  0);
        tbl[7]  = mk(1, 20,   0, 1, 20,  0, 10);
        tbl[8]  = mk(1, 20,   0, 2, 20,  0,  0);
        tbl[9]  = mk(1, 20,   0, 1,  0, 10, 10);
        tbl[10] = mk(1, 20,   0, 2,  0, 10,  0);
        tbl[11] = mk(0, 10,   0, 1, 10, 20, 10);
        tbl[12] = mk(0, 10,   0, 1, 20,  0, 20);
        tbl[13] = mk(0, 10,   0, 1,  0, 10, 30);
        tbl[14] = mk(0, 10,   0, 0,  0,  0, 30);
        tbl[15] = mk(1,  0, 502, 2, 10, 20, 20);
        tbl[16] = mk(0, 30,   0, 1, 10, 20, 30);

        // Reset with random inputs: outputs must sit at reset values.
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_100m);
            rd_en         = 1'($urandom);
            wr_fifo_level = LEN_W'($urandom);
            rd_fifo_level = LEN_W'($urandom);
            wr_ack        = 1'($urandom);
            rd_ack        = 1'($urandom);
            #1;
            chk("rst.wr_req", wr_req, 0);
            chk("rst.rd_req", rd_req, 0);
            chk("rst.wr_addr", wr_addr, 0);
            chk("rst.rd_addr", rd_addr, 0);
            chk("rst.fill", ring_fill, 0);
            chk("rst.busy", busy, 0);
            chk("rst.err", err, 0);
        end
        do_reset();
        begin
            bit seen;
            seen = 0;
            repeat (100) begin
                @(negedge clk_100m);
                if (wr_req || rd_req || busy) seen = 1;
            end
            chk("rst.quiet_100", seen, 0);
        end

        do_reset();
        for (int i = 0; i < 4; i++) apply_vec(t3[i], $sformatf("wrap%0d", i));
        chk("wrap.wr_addr", wr_addr, 0);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.err", i), err, 0);
        end

        // Sticky error, then reset in the middle of a read burst.
        do_reset();
        @(negedge clk_100m);
        wr_ack = 1'b1;
        @(negedge clk_100m);
        wr_ack = 1'b0;
        chk("err.set", err, 1);
        apply_vec(mk(0, 10, 0, 1, 0, 10, 10), "err_wr");
        chk("err.sticky", err, 1);
        set_in(1, 0, 0);
        begin
            int t;
            t = 0;
            while (!rd_req && t < 30) begin
                @(negedge clk_100m);
                t++;
            end
            chk("abort.rd_req_seen", rd_req, 1);
        end
        repeat (3) begin
            rd_ack = 1'b1;
            @(negedge clk_100m);
            rd_ack = 1'b0;
        end
        #2;
        rstn = 1'b0;
        #1;
        chk("abort.rd_req", rd_req, 0);
        chk("abort.err", err, 0);
        chk("abort.busy", busy, 0);
        chk("abort.fill", ring_fill, 0);
        chk("abort.wr_addr", wr_addr, 0);
        set_in(0, 0, 0);
        @(negedge clk_100m);
        rstn = 1'b1;
        @(negedge clk_100m);
        rd_ack = 1'b1;
        @(negedge clk_100m);
        rd_ack = 1'b0;
        chk("err.rd_ack_idle", err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
